// File: rtl/capture_ctrl_if.sv
// Handshake/status bundle between the command/trigger side and capture_ctrl.
// The master drives the controls; the slave (capture_ctrl) drives the RAM write port and status.
interface capture_ctrl_if #(
   parameter int ADDR_W = 9
);
   logic              run;
   logic              stop;
   logic              wrt_smpl;
   logic              triggered;
   logic [ADDR_W-1:0] trig_pos;
   logic              done_clr;
   logic              armed;
   logic              set_capture_done;
   logic              capture_done;
   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [ADDR_W-1:0] trig_addr;
   logic              busy;

   modport master (
      output run, stop, wrt_smpl, triggered, trig_pos, done_clr,
      input  armed, set_capture_done, capture_done, we, waddr, trig_addr, busy
   );

   modport slave (
      input  run, stop, wrt_smpl, triggered, trig_pos, done_clr,
      output armed, set_capture_done, capture_done, we, waddr, trig_addr, busy
   );
endinterface

// File: rtl/capture_ctrl.sv
// Capture sequencer: circular sample-RAM writer with pre-trigger arming and post-trigger count.
// Optional AUTO_REARM_EN: a done_clr pulse in DONE restarts a capture like run.
module capture_ctrl #(
   parameter int ENTRIES = 384,
   parameter int ADDR_W  = 9
) (
   input  logic         clk,
   input  logic         rst,
   capture_ctrl_if.slave bus
);

   localparam logic [ADDR_W:0]   LP_ENTRIES = (ADDR_W+1)'(ENTRIES);
   localparam logic [ADDR_W-1:0] LP_LAST    = ADDR_W'(ENTRIES-1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CAPT = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_next;

   logic [ADDR_W-1:0] r_waddr;
   logic [ADDR_W:0]   r_smpl_cnt;
   logic [ADDR_W-1:0] r_trig_cnt;
   logic [ADDR_W-1:0] r_trig_addr;
   logic              r_capture_done;

   logic              w_start;
   logic              w_wr;
   logic              w_set_done;
   logic              w_hit;
   logic              w_rearm;
   logic [ADDR_W:0]   w_hist_sum;

`ifdef AUTO_REARM_EN
   assign w_rearm = bus.done_clr;
`else
   assign w_rearm = 1'b0;
`endif

   assign w_hit      = bus.triggered && (r_trig_cnt == bus.trig_pos);
   // smpl_cnt <= ENTRIES and trig_pos < ENTRIES, so this sum cannot wrap
   assign w_hist_sum = r_smpl_cnt + {1'b0, bus.trig_pos};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_start      = 1'b0;
      w_wr         = 1'b0;
      w_set_done   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (!bus.stop && bus.run) begin
               w_state_next = ST_CAPT;
               w_start      = 1'b1;
            end
         end
         ST_CAPT: begin
            if (bus.stop) begin
               w_state_next = ST_IDLE;
            end else if (w_hit) begin
               w_state_next = ST_DONE;
               w_set_done   = 1'b1;
            end else if (bus.wrt_smpl) begin
               w_wr = 1'b1;
            end
         end
         ST_DONE: begin
            if (bus.stop) begin
               w_state_next = ST_IDLE;
            end else if (bus.run || w_rearm) begin
               w_state_next = ST_CAPT;
               w_start      = 1'b1;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_waddr    <= '0;
         r_smpl_cnt <= '0;
         r_trig_cnt <= '0;
      end else if (w_start) begin
         r_waddr    <= '0;
         r_smpl_cnt <= '0;
         r_trig_cnt <= '0;
      end else if (w_wr) begin
         r_waddr <= (r_waddr == LP_LAST) ? '0 : r_waddr + ADDR_W'(1);
         if (r_smpl_cnt != LP_ENTRIES) begin
            r_smpl_cnt <= r_smpl_cnt + (ADDR_W+1)'(1);
         end
         if (bus.triggered) begin
            r_trig_cnt <= r_trig_cnt + ADDR_W'(1);
         end
      end
   end

   // The write pointer at the done cycle points at the oldest sample in the ring.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_trig_addr    <= '0;
         r_capture_done <= 1'b0;
      end else begin
         if (w_set_done) begin
            r_trig_addr <= r_waddr;
         end
         if (w_set_done) begin
            r_capture_done <= 1'b1;
         end else if (bus.done_clr || bus.run) begin
            r_capture_done <= 1'b0;
         end
      end
   end

   assign bus.armed            = (r_state == ST_CAPT) && (w_hist_sum >= LP_ENTRIES);
   assign bus.set_capture_done = w_set_done;
   assign bus.capture_done     = r_capture_done;
   assign bus.we               = w_wr;
   assign bus.waddr            = r_waddr;
   assign bus.trig_addr        = r_trig_addr;
   assign bus.busy             = (r_state == ST_CAPT);

endmodule
